// File: rtl/frame_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// frame_buffer_ctrl
//
// Double-buffered 4-bit frame store. The write side accepts the ray marcher's
// pixel stream into the back buffer. The read side serves the front buffer to
// the VGA timing path. The two buffers swap only at a display frame start, and
// only once the back buffer holds a complete frame, so the screen never shows a
// partially rendered image.
//
// Ports
//   clk_in               sole clock
//   rst_in               synchronous, active-high reset
//   hcount_in/vcount_in  write pixel column / row
//   color_in             write pixel colour
//   valid_in             write pixel valid
//   new_frame_in         with valid_in: pixel (0,0) of a new frame
//   ready_out            registered backpressure; transfer = valid_in && ready_out
//   disp_hcount_in/
//   disp_vcount_in       VGA column / row to read
//   disp_frame_start_in  one-cycle pulse at the start of each display frame
//   disp_color_out       colour for the presented column/row, 2 cycles later
//   front_sel_out        buffer currently displayed
//   swap_pending_out     back buffer holds a complete frame awaiting a swap
// -----------------------------------------------------------------------------
module frame_buffer_ctrl #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = $clog2(DISPLAY_WIDTH),
  parameter int V_BITS         = $clog2(DISPLAY_HEIGHT),
  parameter int DISP_H_BITS    = 11,
  parameter int DISP_V_BITS    = 10
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [H_BITS-1:0]      hcount_in,
  input  logic [V_BITS-1:0]      vcount_in,
  input  logic [3:0]             color_in,
  input  logic                   valid_in,
  input  logic                   new_frame_in,
  output logic                   ready_out,
  input  logic [DISP_H_BITS-1:0] disp_hcount_in,
  input  logic [DISP_V_BITS-1:0] disp_vcount_in,
  input  logic                   disp_frame_start_in,
  output logic [3:0]             disp_color_out,
  output logic                   front_sel_out,
  output logic                   swap_pending_out
);

  localparam int DEPTH     = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int ADDR_BITS = $clog2(DEPTH);

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state;
  logic   synced;

  // Write pipeline: one register stage between the transfer and the RAM write.
  logic                 wr_en;
  logic                 wr_sel;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [3:0]           wr_data;

  // Read pipeline.
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_blank0, rd_blank1;
  logic                 rd_sel0, rd_sel1;
  logic [3:0]           mem0_q, mem1_q;

  logic [3:0] mem0 [DEPTH];
  logic [3:0] mem1 [DEPTH];

  // Combinational decode of the current cycle.
  logic xfer, accept, wr_in_range, last_pixel, rd_blank_next;
  int   wr_addr_full, rd_addr_full;

  // NOTE: every signal gets a value on every path through always_comb;
  // a missing assignment would infer a latch.
  always_comb begin
    xfer          = valid_in && ready_out;
    // Before the first new_frame pixel the write side has no raster
    // position to trust, so such transfers are swallowed.
    accept        = xfer && (synced || new_frame_in);
    wr_in_range   = (int'(hcount_in) < DISPLAY_WIDTH) &&
                    (int'(vcount_in) < DISPLAY_HEIGHT);
    last_pixel    = accept &&
                    (int'(hcount_in) == DISPLAY_WIDTH - 1) &&
                    (int'(vcount_in) == DISPLAY_HEIGHT - 1);
    wr_addr_full  = int'(vcount_in) * DISPLAY_WIDTH + int'(hcount_in);
    rd_blank_next = (int'(disp_hcount_in) >= DISPLAY_WIDTH) ||
                    (int'(disp_vcount_in) >= DISPLAY_HEIGHT);
    rd_addr_full  = int'(disp_vcount_in) * DISPLAY_WIDTH + int'(disp_hcount_in);
  end

  // Control: sync flag, write request register and the swap FSM.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= FILL;
      synced           <= 1'b0;
      front_sel_out    <= 1'b0;
      swap_pending_out <= 1'b0;
      ready_out        <= 1'b1;
      wr_en            <= 1'b0;
      wr_sel           <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        synced <= 1'b1;
        if (wr_in_range) begin
          wr_en   <= 1'b1;
          // Latch the target now: a swap on the write edge must not redirect
          // the last pixel into the buffer that is about to become the back.
          wr_sel  <= ~front_sel_out;
          wr_addr <= ADDR_BITS'(wr_addr_full);
          wr_data <= color_in;
        end
      end

      unique case (state)
        FILL: begin
          // A frame start in FILL is ignored, even if it coincides with the
          // last pixel: that frame keeps the old front buffer.
          if (last_pixel) begin
            state            <= PENDING;
            swap_pending_out <= 1'b1;
            ready_out        <= 1'b0;
          end
        end
        PENDING: begin
          if (disp_frame_start_in) begin
            state            <= FILL;
            front_sel_out    <= ~front_sel_out;
            swap_pending_out <= 1'b0;
            ready_out        <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Buffer RAMs: write port from the write pipeline, registered read port.
  // NOTE: the RAM arrays are never reset; a reset loop would prevent BRAM
  // inference, and stale contents are never shown before a full frame lands.
  always_ff @(posedge clk_in) begin
    if (wr_en && !wr_sel) mem0[wr_addr] <= wr_data;
    mem0_q <= mem0[rd_addr];
  end

  always_ff @(posedge clk_in) begin
    if (wr_en && wr_sel) mem1[wr_addr] <= wr_data;
    mem1_q <= mem1[rd_addr];
  end

  // Read pipeline: address/blank/select -> RAM output -> colour register.
  // The buffer select travels with the address, so a read presented in the
  // swap cycle still comes from the old front buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_addr        <= '0;
      rd_blank0      <= 1'b1;
      rd_blank1      <= 1'b1;
      rd_sel0        <= 1'b0;
      rd_sel1        <= 1'b0;
      disp_color_out <= 4'h0;
    end else begin
      rd_addr        <= ADDR_BITS'(rd_addr_full);
      rd_blank0      <= rd_blank_next;
      rd_sel0        <= front_sel_out;
      rd_blank1      <= rd_blank0;
      rd_sel1        <= rd_sel0;
      disp_color_out <= rd_blank1 ? 4'h0 : (rd_sel1 ? mem1_q : mem0_q);
    end
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_ctrl
//
// Self-checking bench for frame_buffer_ctrl on a reduced 40x30 geometry.
// A reference model holds two frame images, the front index, the pending flag
// and the sync flag, and derives the expected display colour of every random
// read. Directed sequences cover sync, backpressure, coincident swap/last
// pixel, blanking, out-of-range writes, tearing and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_frame_buffer_ctrl;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int HB = $clog2(W);
  localparam int VB = $clog2(H);
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [HB-1:0] h = '0;
  logic [VB-1:0] v = '0;
  logic [3:0]    c = '0;
  logic          valid = 1'b0;
  logic          nf = 1'b0;
  logic          fs = 1'b0;
  logic          ready, front, pend;
  logic [3:0]    dcol;

  logic [10:0] rnd_dh = '0, ovr_dh = '0, dh;
  logic [9:0]  rnd_dv = '0, ovr_dv = '0, dv;
  logic        ovr = 1'b0;
  assign dh = ovr ? ovr_dh : rnd_dh;
  assign dv = ovr ? ovr_dv : rnd_dv;

  frame_buffer_ctrl #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .H_BITS        (HB),
    .V_BITS        (VB),
    .DISP_H_BITS   (11),
    .DISP_V_BITS   (10)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .hcount_in          (h),
    .vcount_in          (v),
    .color_in           (c),
    .valid_in           (valid),
    .new_frame_in       (nf),
    .ready_out          (ready),
    .disp_hcount_in     (dh),
    .disp_vcount_in     (dv),
    .disp_frame_start_in(fs),
    .disp_color_out     (dcol),
    .front_sel_out      (front),
    .swap_pending_out   (pend)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. img[b][pixel] is the picture in buffer b (-1 = never
  // written). Expected display colours flow through a 3-entry delay line that
  // matches the 2-cycle read latency after the sampling edge.
  // ---------------------------------------------------------------------------
  int img [2][NPIX];
  bit m_front, m_pend, m_sync, m_xfer;
  int p1, p2, p3;
  bit started = 1'b0;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NPIX; i++) img[b][i] = -1;
  end

  always @(posedge clk) begin : model
    bit acc, last;
    if (rst) begin
      m_front = 1'b0; m_pend = 1'b0; m_sync = 1'b0; m_xfer = 1'b0;
      p1 = 0; p2 = 0; p3 = 0;
    end else begin
      p3 = p2;
      p2 = p1;
      if (int'(dh) >= W || int'(dv) >= H) p1 = 0;
      else                                p1 = img[m_front][int'(dv) * W + int'(dh)];
      m_xfer = valid && !m_pend;
      acc    = m_xfer && (m_sync || nf);
      last   = 1'b0;
      if (acc) begin
        m_sync = 1'b1;
        if (int'(h) < W && int'(v) < H) img[!m_front][int'(v) * W + int'(h)] = int'(c);
        if (int'(h) == W - 1 && int'(v) == H - 1) last = 1'b1;
      end
      if (m_pend && fs) begin
        m_front = !m_front;
        m_pend  = 1'b0;
      end else if (last) begin
        m_pend = 1'b1;
      end
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      check("ready", int'(ready), int'(!m_pend));
      check("front", int'(front), int'(m_front));
      check("pending", int'(pend), int'(m_pend));
      if (p3 >= 0) check("color", int'(dcol), p3);
    end
  end

  // Random display scan, mostly around the active area, sometimes far out.
  always @(negedge clk) begin
    if ($urandom_range(0, 7) == 0) begin
      rnd_dh = 11'($urandom_range(0, 2047));
      rnd_dv = 10'($urandom_range(0, 1023));
    end else begin
      rnd_dh = 11'($urandom_range(0, W + 2));
      rnd_dv = 10'($urandom_range(0, H + 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called and returning at a negedge).
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      valid = 1'b0; nf = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_pixel(input int ph, input int pv, input int pc,
                            input bit pnf, input bit pfs);
    int tries;
    tries = 0;
    h = HB'(ph); v = VB'(pv); c = 4'(pc); nf = pnf; fs = pfs; valid = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    while (!m_xfer && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!m_xfer) check("xfer_timeout", 0, 1);
    valid = 1'b0; nf = 1'b0;
  endtask

  // kind 0: (h+v)&0xF, 1: constant cval, 2: random 0..14.
  task automatic send_frame(input int kind, input int cval, input int first,
                            input int npix, input bit fs_on_last, input bit oor);
    int ph, pv, pc;
    for (int i = first; i < first + npix; i++) begin
      ph = i % W;
      pv = i / W;
      case (kind)
        0:       pc = (ph + pv) & 15;
        1:       pc = cval;
        default: pc = int'($urandom_range(0, 14));
      endcase
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 2)));
      send_pixel(ph, pv, pc, i == 0, fs_on_last && i == NPIX - 1);
      if (oor && i == 100) send_pixel(W, 0, 15, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
  endtask

  task automatic read_at(input string tag, input int x, input int y, input int exp);
    ovr_dh = 11'(x); ovr_dv = 10'(y); ovr = 1'b1;
    @(negedge clk);
    ovr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(tag, int'(dcol), exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence.
  // ---------------------------------------------------------------------------
  initial begin
    int x, y;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    check("rst_ready", int'(ready), 1);
    check("rst_front", int'(front), 0);
    check("rst_pending", int'(pend), 0);
    check("rst_color", int'(dcol), 0);

    // Unsynced pixels, including the last-pixel coordinate, are discarded.
    for (int i = 0; i < 9; i++) send_pixel(i, 0, 15, 1'b0, 1'b0);
    send_pixel(W - 1, H - 1, 15, 1'b0, 1'b0);
    check("presync_pending", int'(pend), 0);
    send_frame(0, 0, 0, NPIX, 1'b0, 1'b0);

    // Backpressure: hold a pixel for 50 cycles while the swap is pending.
    check("bp_pending", int'(pend), 1);
    check("bp_ready", int'(ready), 0);
    h = '0; v = '0; c = 4'h7; nf = 1'b0; valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("bp_hold_ready", int'(ready), 0);
    end
    valid = 1'b0;
    check("bp_hold_pending", int'(pend), 1);
    pulse_fs();
    check("swap_front", int'(front), 1);
    check("swap_ready", int'(ready), 1);
    read_at("read_5_3", 5, 3, 8);
    read_at("presync_3_0", 3, 0, 3);
    read_at("bp_no_xfer_0_0", 0, 0, 0);
    read_at("read_last", W - 1, H - 1, (W - 1 + H - 1) & 15);

    // Blanking.
    read_at("blank_w", W, 0, 0);
    read_at("blank_h", 0, H, 0);
    read_at("blank_max", 639, 479, 0);

    // Out-of-range write inside a frame whose last pixel meets a frame start.
    send_frame(2, 0, 0, NPIX, 1'b1, 1'b1);
    check("sim_front", int'(front), 1);
    check("sim_pending", int'(pend), 1);
    idle(3);
    pulse_fs();
    check("sim_swap_front", int'(front), 0);
    for (int i = 0; i < W; i++) read_at("oor_row0", i, 0, img[0][i]);
    read_at("oor_row1", 0, 1, img[0][W]);

    // No tearing: frame A (0x3) shown, half of frame B (0xC) written.
    send_frame(1, 3, 0, NPIX, 1'b0, 1'b0);
    pulse_fs();
    check("tear_a_front", int'(front), 1);
    send_frame(1, 12, 0, NPIX / 2, 1'b0, 1'b0);
    pulse_fs();
    check("tear_front", int'(front), 1);
    check("tear_pending", int'(pend), 0);
    for (int k = 0; k < 8; k++) begin
      x = int'($urandom_range(0, W - 1));
      y = int'($urandom_range(0, H - 1));
      read_at("tear_read", x, y, 3);
    end

    // Reset after 1000 pixels of frame B.
    send_frame(1, 12, NPIX / 2, 1000 - NPIX / 2, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_front", int'(front), 0);
    check("mid_rst_ready", int'(ready), 1);
    check("mid_rst_color", int'(dcol), 0);
    check("mid_rst_pending", int'(pend), 0);
    for (int i = 0; i < 19; i++)
      send_pixel(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                 15, 1'b0, 1'b0);
    send_pixel(W - 1, H - 1, 15, 1'b0, 1'b0);
    check("mid_rst_discard", int'(pend), 0);

    // Fresh random frame after the reset, then random reads of it.
    send_frame(2, 0, 0, NPIX, 1'b0, 1'b0);
    pulse_fs();
    check("post_rst_front", int'(front), 1);
    for (int k = 0; k < 16; k++) begin
      x = int'($urandom_range(0, W - 1));
      y = int'($urandom_range(0, H - 1));
      read_at("post_rst_read", x, y, img[1][y * W + x]);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Double-buffered 4-bit frame store directly downstream of `ray_marcher`. It accepts the marcher's pixel stream (`hcount`/`vcount`/`color`/`valid`/`new_frame`) into a back buffer and serves the front buffer to the VGA timing path. Buffers swap only at a display frame boundary, so the screen never shows a partially rendered frame. Backpressure to the marcher is a single `ready_out` line.

## Interface

Parameters:
- `DISPLAY_WIDTH`, default 320: rendered image width in pixels.
- `DISPLAY_HEIGHT`, default 240: rendered image height in pixels.
- `H_BITS`, default `$clog2(DISPLAY_WIDTH)`: width of the write-side column coordinate.
- `V_BITS`, default `$clog2(DISPLAY_HEIGHT)`: width of the write-side row coordinate.
- `DISP_H_BITS`, default 11: width of the display-side column count.
- `DISP_V_BITS`, default 10: width of the display-side row count.

Ports:
- `clk_in`, input, 1: sole clock for the block. One clock; reset is synchronous and active-high.
- `rst_in`, input, 1: synchronous, active-high reset.
- `hcount_in`, input, `H_BITS`: column of the write pixel.
- `vcount_in`, input, `V_BITS`: row of the write pixel.
- `color_in`, input, 4: colour of the write pixel.
- `valid_in`, input, 1: write pixel is valid.
- `new_frame_in`, input, 1: qualified by `valid_in`; marks pixel (0,0) of a new frame.
- `ready_out`, input/output, 1 (output): block accepts a pixel this cycle. A transfer occurs when `valid_in && ready_out`.
- `disp_hcount_in`, input, `DISP_H_BITS`: VGA column.
- `disp_vcount_in`, input, `DISP_V_BITS`: VGA row.
- `disp_frame_start_in`, input, 1: one-cycle pulse at the start of each display frame.
- `disp_color_out`, output, 4: pixel colour for the VGA column/row, delivered 2 cycles later.
- `front_sel_out`, output, 1: index of the buffer currently being displayed.
- `swap_pending_out`, output, 1: the back buffer holds a complete frame awaiting a swap.

## Operation

**Storage**
- Two arrays, each `DISPLAY_WIDTH*DISPLAY_HEIGHT` x 4 bits, inferred as BRAM.
- Address = `v*DISPLAY_WIDTH + h`, computed at full width with no truncation.

**Write-side sync flag**
- `synced` is cleared by reset.
- While `synced`=0, every transfer is discarded.
- The first transfer with `new_frame_in`=1 sets `synced` and is written.

**Write path**
- A transfer is written to buffer `~front_sel` at the following edge.
- A transfer with `hcount_in >= DISPLAY_WIDTH` or `vcount_in >= DISPLAY_HEIGHT` is accepted but not written.
- A transfer with coordinates `(W-1, H-1)` sets `swap_pending`.

**Backpressure**
- `ready_out` is a registered output equal to `!swap_pending`.
- While it is low, upstream must hold its pixel stable.

**Swap FSM (two states)**
- FILL:
  - Stays in FILL on all other transfers.
  - Moves to PENDING after the last-pixel transfer.
- PENDING:
  - On `disp_frame_start_in`, toggles `front_sel`, clears `swap_pending`, and returns to FILL.
- Simultaneous events:
  - If the last-pixel transfer and `disp_frame_start_in` occur in the same cycle while in FILL, go to PENDING. No swap happens in that frame.
  - `disp_frame_start_in` while in FILL has no effect.

**Read path**
- Reads are taken from buffer `front_sel`.
- If `disp_hcount_in >= DISPLAY_WIDTH` or `disp_vcount_in >= DISPLAY_HEIGHT`, the pipeline carries a blank flag and `disp_color_out`=0.

**Reset values**
- `front_sel_out`=0.
- `swap_pending_out`=0.
- `ready_out`=1 in the first cycle after reset.
- `disp_color_out`=0.
- `synced`=0.
- Memory contents are not cleared.

**Reset mid-operation**
- Returns the block to FILL and unsynced.
- A partially written back buffer is abandoned.

## Timing

**Read latency** is 2 cycles:
- Cycle 0: address and blank flag registered.
- Cycle 1: BRAM output.
- Cycle 2: `disp_color_out` registered.

**Swap timing**
- Occurs at the edge that samples `disp_frame_start_in`.
- Reads presented in that cycle use the old front buffer.
- Reads presented from the next cycle onward use the new front buffer.

**Write timing**
- A write occurs 1 cycle after the transfer.
- A display read of the same address must not occur in the same cycle; this is guaranteed because writes go to the back buffer only.

**ready_out**
- Deasserts the cycle after the last-pixel transfer.
- Reasserts the cycle after the swap.

**Throughput**
- One pixel per cycle while `ready_out`=1.

## Test plan

- **Unsynced discard:** after reset, stream 10 pixels with `new_frame_in`=0, then a full 320x240 frame starting with `new_frame_in`=1 and every pixel = `(h+v)&0xF`, then pulse `disp_frame_start_in`. Required:
  - The 10 pre-sync pixels leave no trace.
  - `front_sel_out`=1.
  - Reading (5,3) returns 8 exactly 2 cycles later.
- **Backpressure:** after the last pixel (319,239), `ready_out`=0 on the next cycle. Hold `valid_in`=1 for 50 cycles. Required:
  - No new transfers occur.
  - `swap_pending_out`=1.
  - `ready_out`=1 one cycle after `disp_frame_start_in`.
- **Simultaneous events:** last-pixel transfer in the same cycle as `disp_frame_start_in`. Required:
  - `front_sel_out` is unchanged.
  - `swap_pending_out`=1.
  - The swap occurs at the next `disp_frame_start_in`.
- **Blanking and out-of-range writes:** read at (320,0), (0,240) and (639,479). Required:
  - `disp_color_out`=0 for each read.
  - A write at `hcount_in`=320 leaves row 0 of the next frame unaffected.
- **No tearing:** frame A = all 0x3 is shown. Write half of frame B = all 0xC and pulse `disp_frame_start_in`. Required: front buffer pixels still read 0x3.
- **Reset mid-frame:** assert `rst_in` after 1000 pixels of frame 2. Required:
  - `front_sel_out`=0.
  - `ready_out`=1.
  - `disp_color_out`=0.
  - Pixels are discarded until the next `new_frame_in`.
